pwm_fade_ctrl: RTL and testbench

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

---
 rtl/pwm_fade_ctrl.sv | 118 +++++++++++
 tb/tb_pwm_fade_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_ctrl.sv
// PWM duty fader: free-running period counter plus an IDLE/RAMP FSM that steps duty toward a target.
// Optional build macro PWM_FADE_BREATHE_EN adds a breathe input for continuous target<->0 cycling.
module pwm_fade_ctrl #(
    parameter int DUTY_W = 4,
    parameter int PERIOD = 8,
    parameter int RATE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic              stop,
    input  logic [DUTY_W-1:0] target,
    input  logic [RATE_W-1:0] rate,
`ifdef PWM_FADE_BREATHE_EN
    input  logic              breathe,
`endif
    output logic [DUTY_W-1:0] duty,
    output logic              period_end,
    output logic              busy,
    output logic              done
);
    // state | meaning
    // IDLE  | duty held, waiting for start
    // RAMP  | duty moves one code toward goal every rate+1 PWM periods

    localparam int PCNT_W = $clog2(PERIOD);

    typedef enum logic {IDLE, RAMP} state_t;

    state_t            state;
    logic [PCNT_W-1:0] pcnt;
    logic [RATE_W-1:0] dcnt;
    logic [RATE_W-1:0] rate_q;
    logic [DUTY_W-1:0] tgt_q;
    logic [DUTY_W-1:0] goal;
    logic [DUTY_W-1:0] duty_nxt;

`ifdef PWM_FADE_BREATHE_EN
    logic breathe_q;
    logic phase_q;

    // phase_q high means the breathe cycle is currently heading back down to 0
    assign goal = phase_q ? '0 : tgt_q;
`else
    assign goal = tgt_q;
`endif

    assign period_end = ena && (pcnt == PCNT_W'(PERIOD - 1));

    // Holding when already at goal keeps duty in range for a degenerate breathe target of 0
    assign duty_nxt = (duty < goal) ? duty + DUTY_W'(1) :
                      (duty > goal) ? duty - DUTY_W'(1) : duty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pcnt   <= '0;
            dcnt   <= '0;
            rate_q <= '0;
            tgt_q  <= '0;
            duty   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef PWM_FADE_BREATHE_EN
            breathe_q <= 1'b0;
            phase_q   <= 1'b0;
`endif
        end else if (ena) begin
            pcnt <= (pcnt == PCNT_W'(PERIOD - 1)) ? '0 : pcnt + PCNT_W'(1);
            done <= 1'b0;
            if (stop) begin
                state <= IDLE;
                busy  <= 1'b0;
                dcnt  <= '0;
            end else if (start) begin
                tgt_q  <= target;
                rate_q <= rate;
                dcnt   <= '0;
`ifdef PWM_FADE_BREATHE_EN
                breathe_q <= breathe;
                phase_q   <= 1'b0;
`endif
                if (target == duty) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state <= RAMP;
                    busy  <= 1'b1;
                end
            end else if (state == RAMP && period_end) begin
                if (dcnt == rate_q) begin
                    dcnt <= '0;
                    duty <= duty_nxt;
                    if (duty_nxt == goal) begin
`ifdef PWM_FADE_BREATHE_EN
                        if (breathe_q) begin
                            phase_q <= !phase_q;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
`else
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`endif
                    end
                end else begin
                    dcnt <= dcnt + RATE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl: stimulus queues expected (duty, busy, done, gap) events,
// a monitor thread pops one whenever the output tuple changes.
module tb_pwm_fade_ctrl;
    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       ena    = 1'b1;
    logic       start  = 1'b0;
    logic       stop   = 1'b0;
    logic [3:0] target = 4'd0;
    logic [3:0] rate   = 4'd0;
`ifdef PWM_FADE_BREATHE_EN
    logic       breathe = 1'b0;
`endif
    logic [3:0] duty;
    logic       period_end;
    logic       busy;
    logic       done;

    pwm_fade_ctrl #(.DUTY_W(4), .PERIOD(8), .RATE_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start),
        .stop       (stop),
        .target     (target),
        .rate       (rate),
`ifdef PWM_FADE_BREATHE_EN
        .breathe    (breathe),
`endif
        .duty       (duty),
        .period_end (period_end),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // gap = clock edges since the previous output event, 0 means not checked
    typedef struct {
        logic [3:0] duty;
        logic       busy;
        logic       done;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic expect_ev(input logic [3:0] d, input logic b, input logic dn, input int g);
        exp_t e;
        e.duty = d;
        e.busy = b;
        e.done = dn;
        e.gap  = g;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic monitor();
        logic [5:0] prev;
        logic [5:0] cur;
        int         last;
        int         gap;
        exp_t       e;
        prev = 6'b0;
        last = 0;
        forever begin
            @(negedge clk);
            cur = {duty, busy, done};
            if (cur !== prev) begin
                gap  = cyc - last;
                last = cyc;
                prev = cur;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got duty=%0d busy=%0b done=%0b at cycle %0d, want no event",
                             duty, busy, done, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (duty !== e.duty || busy !== e.busy || done !== e.done ||
                        (e.gap != 0 && gap != e.gap)) begin
                        n_fail++;
                        $display("FAIL event: got duty=%0d busy=%0b done=%0b gap=%0d, want duty=%0d busy=%0b done=%0b gap=%0d",
                                 duty, busy, done, gap, e.duty, e.busy, e.done, e.gap);
                    end
                end
            end
        end
    endtask

    task automatic wait_duty(input logic [3:0] d, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (duty !== d && n < 400);
        if (duty !== d) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout_%s: duty=%0d, want %0d", name, duty, d);
        end
    endtask

    task automatic wait_pe(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (period_end !== 1'b1 && n < 40);
        if (period_end !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout_pe_%s: period_end=%0b, want 1", name, period_end);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (exp_q.size() != 0 && n < 600);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout_drain_%s: %0d events pending, want 0", name, exp_q.size());
        end
    endtask

    // called at a negedge; the request is sampled on the following rising edge
    task automatic issue_start(input logic [3:0] t, input logic [3:0] r);
        start  = 1'b1;
        target = t;
        rate   = r;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        fork
            monitor();
            begin
                #2 rst_n = 1'b0;
                repeat (2) @(negedge clk);
                check("rst_duty", int'(duty), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                check("rst_period_end", int'(period_end), 0);
                rst_n = 1'b1;

                // up-ramp 0 -> 3, one step per period
                expect_ev(4'd0, 1'b1, 1'b0, 0);
                expect_ev(4'd1, 1'b1, 1'b0, 8);
                expect_ev(4'd2, 1'b1, 1'b0, 8);
                expect_ev(4'd3, 1'b0, 1'b1, 8);
                expect_ev(4'd3, 1'b0, 1'b0, 1);
                wait_pe("up");
                issue_start(4'd3, 4'd0);
                wait_drain("up");

                // down-ramp 3 -> 0
                expect_ev(4'd3, 1'b1, 1'b0, 0);
                expect_ev(4'd2, 1'b1, 1'b0, 8);
                expect_ev(4'd1, 1'b1, 1'b0, 8);
                expect_ev(4'd0, 1'b0, 1'b1, 8);
                expect_ev(4'd0, 1'b0, 1'b0, 1);
                wait_pe("down");
                issue_start(4'd0, 4'd0);
                wait_drain("down");

                // target equals duty: done next cycle, busy stays low
                expect_ev(4'd0, 1'b0, 1'b1, 0);
                expect_ev(4'd0, 1'b0, 1'b0, 1);
                issue_start(4'd0, 4'd0);
                wait_drain("noop");

                // 0 -> 10 retargeted to 4 at duty 6, restart coincident with a step skips it
                expect_ev(4'd0, 1'b1, 1'b0, 0);
                for (int d = 1; d <= 6; d++) expect_ev(4'(d), 1'b1, 1'b0, 8);
                expect_ev(4'd5, 1'b1, 1'b0, 16);
                expect_ev(4'd4, 1'b0, 1'b1, 8);
                expect_ev(4'd4, 1'b0, 1'b0, 1);
                wait_pe("retgt");
                issue_start(4'd10, 4'd0);
                wait_duty(4'd6, "retgt6");
                wait_pe("retgt_co");
                issue_start(4'd4, 4'd0);
                wait_drain("retgt");

                // stop and start together at duty 2: stop wins, no done
                expect_ev(4'd4, 1'b1, 1'b0, 0);
                expect_ev(4'd3, 1'b1, 1'b0, 8);
                expect_ev(4'd2, 1'b1, 1'b0, 8);
                expect_ev(4'd2, 1'b0, 1'b0, 1);
                wait_pe("stop");
                issue_start(4'd0, 4'd0);
                wait_duty(4'd2, "stop2");
                stop   = 1'b1;
                start  = 1'b1;
                target = 4'd9;
                @(posedge clk);
                #1 stop = 1'b0;
                start = 1'b0;
                wait_drain("stop");
                repeat (40) @(negedge clk);
                check("stop_duty", int'(duty), 2);
                check("stop_busy", int'(busy), 0);

                // reset mid-ramp at duty 5
                expect_ev(4'd2, 1'b1, 1'b0, 0);
                expect_ev(4'd3, 1'b1, 1'b0, 8);
                expect_ev(4'd4, 1'b1, 1'b0, 8);
                expect_ev(4'd5, 1'b1, 1'b0, 8);
                expect_ev(4'd0, 1'b0, 1'b0, 0);
                wait_pe("rst");
                issue_start(4'd8, 4'd0);
                wait_duty(4'd5, "rst5");
                #2 rst_n = 1'b0;
                #1;
                check("midrst_duty", int'(duty), 0);
                check("midrst_busy", int'(busy), 0);
                check("midrst_done", int'(done), 0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                wait_drain("rst");
                repeat (40) @(negedge clk);

                // rate 2 from 0 to 2, with ena low for 10 cycles (start ignored meanwhile)
                expect_ev(4'd0, 1'b1, 1'b0, 0);
                expect_ev(4'd1, 1'b1, 1'b0, 24);
                expect_ev(4'd2, 1'b0, 1'b1, 34);
                expect_ev(4'd2, 1'b0, 1'b0, 1);
                wait_pe("rate");
                issue_start(4'd2, 4'd2);
                wait_duty(4'd1, "rate1");
                ena    = 1'b0;
                start  = 1'b1;
                target = 4'd0;
                repeat (10) @(posedge clk);
                #1 ena = 1'b1;
                start = 1'b0;
                wait_drain("rate");

`ifdef PWM_FADE_BREATHE_EN
                expect_ev(4'd0, 1'b0, 1'b0, 0);
                @(negedge clk);
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                wait_drain("brst");

                expect_ev(4'd0, 1'b1, 1'b0, 0);
                expect_ev(4'd1, 1'b1, 1'b0, 8);
                expect_ev(4'd2, 1'b1, 1'b0, 8);
                expect_ev(4'd1, 1'b1, 1'b0, 8);
                expect_ev(4'd0, 1'b1, 1'b0, 8);
                expect_ev(4'd1, 1'b1, 1'b0, 8);
                expect_ev(4'd2, 1'b1, 1'b0, 8);
                expect_ev(4'd2, 1'b0, 1'b0, 1);
                wait_pe("br");
                breathe = 1'b1;
                issue_start(4'd2, 4'd0);
                breathe = 1'b0;
                wait_duty(4'd2, "br2a");
                wait_duty(4'd0, "br0");
                wait_duty(4'd2, "br2b");
                stop = 1'b1;
                @(posedge clk);
                #1 stop = 1'b0;
                wait_drain("br");
                repeat (30) @(negedge clk);
                check("br_duty", int'(duty), 2);
                check("br_busy", int'(busy), 0);
`endif

                n_cmp++;
                if (exp_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL leftover_events: got %0d pending, want 0", exp_q.size());
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
                $finish;
            end
        join
    end

endmodule
